// File: rtl/keypad_emulator.sv
// keypad_emulator
//   Stands in for a 4x4 active-low matrix keypad. Scripted key presses are
//   queued through a valid/ready port. Each press closes one row/column
//   contact for a programmed number of cycles, followed by a released gap.
//
//   Optional feature macro: KEYPAD_EMU_BOUNCE_EN. When it is defined, each
//   press edge is preceded by BOUNCE_CYCLES cycles of alternating contact.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   keypadRow  in   [3:0] scanner row drive, active-low
//   keypadCol  out  [3:0] column sense, active-low, idle 4'b1111
//   cmd_valid  in   command offered
//   cmd_ready  out  queue not full
//   cmd_key    in   [3:0] {row, col} of the key
//   cmd_hold   in   [HOLD_W-1:0] contact-closed cycles (0 behaves as 1)
//   busy       out  FSM active or queue non-empty
//   done       out  one-cycle pulse on the first released (gap) cycle
//
// States
//   S_IDLE       | contact open, pops the next command when one is queued
//   S_PRESS      | contact closed for hold_q cycles
//   S_GAP        | contact open for GAP_CYCLES cycles
//   S_BOUNCE_IN  | contact follows bounce_q[0] before the press (bounce build)
//   S_BOUNCE_OUT | contact follows bounce_q[0] after the press (bounce build)
module keypad_emulator #(
  parameter int HOLD_W        = 16,
  parameter int GAP_CYCLES    = 1000,
  parameter int FIFO_DEPTH    = 4,
  parameter int BOUNCE_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        keypadRow,
  output logic [3:0]        keypadCol,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_key,
  input  logic [HOLD_W-1:0] cmd_hold,
  output logic              busy,
  output logic              done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int EW = 4 + HOLD_W;

  if (GAP_CYCLES < 1 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      BOUNCE_CYCLES < 1) begin : g_bad_params
    $error("keypad_emulator: illegal parameter value");
  end

  // Command FIFO; pointers carry one extra wrap bit to tell full from empty
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic          full, empty, push, pop;
  logic [EW-1:0] head;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign head      = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {cmd_key, cmd_hold};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS,
    S_GAP
`ifdef KEYPAD_EMU_BOUNCE_EN
    , S_BOUNCE_IN,
    S_BOUNCE_OUT
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        key_q, key_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              closed;
`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam int BW = $clog2(BOUNCE_CYCLES + 1);
  logic [BW-1:0]     bounce_q, bounce_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      key_q    <= '0;
      hold_q   <= '0;
      gap_q    <= '0;
`ifdef KEYPAD_EMU_BOUNCE_EN
      bounce_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      key_q    <= key_d;
      hold_q   <= hold_d;
      gap_q    <= gap_d;
`ifdef KEYPAD_EMU_BOUNCE_EN
      bounce_q <= bounce_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    hold_d   = hold_q;
    gap_d    = gap_q;
`ifdef KEYPAD_EMU_BOUNCE_EN
    bounce_d = bounce_q;
`endif
    pop      = 1'b0;
    closed   = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop    = 1'b1;
          key_d  = head[EW-1:HOLD_W];
          hold_d = (head[HOLD_W-1:0] == '0) ? HOLD_W'(1) : head[HOLD_W-1:0];
`ifdef KEYPAD_EMU_BOUNCE_EN
          bounce_d = '0;
          state_d  = S_BOUNCE_IN;
`else
          state_d  = S_PRESS;
`endif
        end
      end
      S_PRESS: begin
        closed = 1'b1;
        if (hold_q == HOLD_W'(1)) begin
`ifdef KEYPAD_EMU_BOUNCE_EN
          bounce_d = '0;
          state_d  = S_BOUNCE_OUT;
`else
          gap_d    = GW'(GAP_CYCLES);
          state_d  = S_GAP;
`endif
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      S_GAP: begin
        done = (gap_q == GW'(GAP_CYCLES));
        if (gap_q == GW'(1)) state_d = S_IDLE;
        else                 gap_d   = gap_q - 1'b1;
      end
`ifdef KEYPAD_EMU_BOUNCE_EN
      // Counter starts at 0, so the first bounce cycle is open
      S_BOUNCE_IN: begin
        closed = bounce_q[0];
        if (bounce_q == BW'(BOUNCE_CYCLES - 1)) state_d  = S_PRESS;
        else                                     bounce_d = bounce_q + 1'b1;
      end
      S_BOUNCE_OUT: begin
        closed = bounce_q[0];
        if (bounce_q == BW'(BOUNCE_CYCLES - 1)) begin
          gap_d   = GW'(GAP_CYCLES);
          state_d = S_GAP;
        end else begin
          bounce_d = bounce_q + 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Passive switch: the column follows the row drive combinationally
  always_comb begin
    keypadCol = 4'b1111;
    if (closed && !keypadRow[key_q[3:2]]) keypadCol[key_q[1:0]] = 1'b0;
  end

  assign busy = (state_q != S_IDLE) || !empty;

endmodule

// File: tb/tb_keypad_emulator.sv
module tb_keypad_emulator;
  localparam int HOLD_W = 16;
  localparam int GAP    = 3;
  localparam int DEPTH  = 4;
  localparam int BOUNCE = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        keypadRow = 4'hF;
  logic [3:0]        keypadCol;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [3:0]        cmd_key = 4'h0;
  logic [HOLD_W-1:0] cmd_hold = '0;
  logic              busy, done;

  keypad_emulator #(
    .HOLD_W(HOLD_W), .GAP_CYCLES(GAP), .FIFO_DEPTH(DEPTH), .BOUNCE_CYCLES(BOUNCE)
  ) dut (
    .clk(clk), .rst(rst), .keypadRow(keypadRow), .keypadCol(keypadCol),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_key(cmd_key),
    .cmd_hold(cmd_hold), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct { logic [3:0] col; int len; } exp_t;
  typedef struct { logic [3:0] col; int len; int gap; } obs_t;
  exp_t exp_q[$];
  obs_t obs_q[$];

  // Press monitor: records each closed run with the open cycles before it
  int         mon_run = 0, mon_open = 0, mon_gap = 0, done_cnt = 0;
  logic [3:0] mon_col = 4'hF;
  always @(negedge clk) begin
    obs_t o;
    #2;
    if (rst) begin
      mon_run  = 0;
      mon_open = 0;
    end else begin
      if (done) done_cnt++;
      if (keypadCol != 4'hF) begin
        if (mon_run == 0) begin
          mon_col = keypadCol;
          mon_gap = mon_open;
        end
        mon_run++;
      end else begin
        if (mon_run > 0) begin
          o.col = mon_col; o.len = mon_run; o.gap = mon_gap;
          obs_q.push_back(o);
          mon_run  = 0;
          mon_open = 0;
        end
        mon_open++;
      end
    end
  end

  function automatic logic [3:0] col_of(input logic [3:0] key);
    logic [3:0] c;
    c = 4'b0001 << key[1:0];
    return ~c;
  endfunction

  function automatic exp_t mk_exp(input logic [3:0] key, input int hold);
    exp_t e;
    e.col = col_of(key);
    e.len = (hold == 0) ? 1 : hold;
    return e;
  endfunction

  task automatic wait_obs(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      if (obs_q.size() > 0) got = 1'b1;
      else @(negedge clk);
    end
    if (obs_q.size() > 0) got = 1'b1;
  endtask

  task automatic test_reset();
    logic [3:0] pats [4];
    pats[0] = 4'hF; pats[1] = 4'h0; pats[2] = 4'hE; pats[3] = 4'h5;
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      keypadRow = pats[i];
      #1;
      total++;
      if (keypadCol !== 4'hF) begin bad++; $display("FAIL reset_col row=%b: got %b want 1111", pats[i], keypadCol); end
    end
    total++;
    if ({cmd_ready, busy, done} !== 3'b100) begin bad++; $display("FAIL reset_flags: got ready/busy/done=%b want 100", {cmd_ready, busy, done}); end
    @(negedge clk);
    rst = 1'b0;
    keypadRow = 4'hF;
    @(negedge clk);
    total++;
    if ({cmd_ready, busy} !== 2'b10) begin bad++; $display("FAIL post_reset_flags: got ready/busy=%b want 10", {cmd_ready, busy}); end
  endtask

  task automatic test_single_key();
    logic [3:0] rows [4];
    exp_t e;
    logic [3:0] want_col;
    rows[0] = 4'b1110; rows[1] = 4'b1101; rows[2] = 4'b1011; rows[3] = 4'b0111;
    cmd_key = 4'h6; cmd_hold = 5; cmd_valid = 1'b1;
    #1;
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL single_ready: got %b want 1", cmd_ready); end
    e.col = 4'b1011; e.len = 5;
    exp_q.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b0;
    e = exp_q.pop_front();
    for (int k = 0; k <= 10; k++) begin
      keypadRow = rows[k % 4];
      #1;
      want_col = (k >= 1 && k <= e.len && keypadRow == 4'b1101) ? e.col : 4'hF;
      total++;
      if (keypadCol !== want_col) begin bad++; $display("FAIL single_col k=%0d row=%b: got %b want %b", k, keypadRow, keypadCol, want_col); end
      total++;
      if (done !== (k == e.len + 1)) begin bad++; $display("FAIL single_done k=%0d: got %b want %b", k, done, (k == e.len + 1)); end
      total++;
      if (busy !== (k <= e.len + GAP)) begin bad++; $display("FAIL single_busy k=%0d: got %b want %b", k, busy, (k <= e.len + GAP)); end
      @(negedge clk);
    end
    keypadRow = 4'hF;
    obs_q.delete();
  endtask

  task automatic test_hold_zero();
    exp_t e;
    obs_t o;
    bit   got;
    keypadRow = 4'h0;
    obs_q.delete();
    cmd_key = 4'h3; cmd_hold = 0; cmd_valid = 1'b1;
    exp_q.push_back(mk_exp(4'h3, 0));
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_obs(20, got);
    total++;
    if (!got) begin
      bad++; $display("FAIL hold0_timeout: got no press want one");
      exp_q.delete();
    end else begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      if (o.col !== e.col || o.len != e.len) begin
        bad++; $display("FAIL hold0_press: got col=%b len=%0d want col=%b len=%0d", o.col, o.len, e.col, e.len);
      end
    end
    repeat (GAP + 3) @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL hold0_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_queue_full();
    logic [3:0] keys [5];
    int         holds [5];
    exp_t       e;
    obs_t       o;
    bit         got;
    bit         want_ready;
    int         dc0;
    keys[0] = 4'h0; keys[1] = 4'h5; keys[2] = 4'hA; keys[3] = 4'hF; keys[4] = 4'h4;
    holds[0] = 6; holds[1] = 2; holds[2] = 3; holds[3] = 1; holds[4] = 4;
    keypadRow = 4'h0;
    obs_q.delete();
    dc0 = done_cnt;
    for (int i = 0; i < 7; i++) begin
      if (i < 5) begin
        cmd_key = keys[i]; cmd_hold = HOLD_W'(holds[i]); want_ready = 1'b1;
        exp_q.push_back(mk_exp(keys[i], holds[i]));
      end else begin
        cmd_key = 4'h9; cmd_hold = 7; want_ready = 1'b0;
      end
      cmd_valid = 1'b1;
      #1;
      total++;
      if (cmd_ready !== want_ready) begin bad++; $display("FAIL full_ready i=%0d: got %b want %b", i, cmd_ready, want_ready); end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_obs(60, got);
      total++;
      if (!got) begin
        bad++; $display("FAIL full_timeout i=%0d: got no press want one", i);
      end else begin
        o = obs_q.pop_front(); e = exp_q.pop_front();
        if (o.col !== e.col || o.len != e.len || (i > 0 && o.gap != GAP + 1)) begin
          bad++;
          $display("FAIL full_press i=%0d: got col=%b len=%0d gap=%0d want col=%b len=%0d gap=%0d",
                   i, o.col, o.len, o.gap, e.col, e.len, GAP + 1);
        end
      end
    end
    exp_q.delete();
    repeat (30) @(negedge clk);
    total++;
    if (obs_q.size() != 0) begin bad++; $display("FAIL full_extra: got %0d extra presses want 0", obs_q.size()); end
    total++;
    if (done_cnt - dc0 != 5) begin bad++; $display("FAIL full_done: got %0d pulses want 5", done_cnt - dc0); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL full_idle: got busy=%b want 0", busy); end
    obs_q.delete();
  endtask

  task automatic test_multi_row();
    exp_t e;
    obs_t o;
    bit   got;
    keypadRow = 4'b0000;
    obs_q.delete();
    cmd_key = 4'hF; cmd_hold = 3; cmd_valid = 1'b1;
    e.col = 4'b0111; e.len = 3;
    exp_q.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_obs(20, got);
    total++;
    if (!got) begin
      bad++; $display("FAIL multirow_timeout: got no press want one");
      exp_q.delete();
    end else begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      if (o.col !== e.col || o.len != e.len) begin
        bad++; $display("FAIL multirow_press: got col=%b len=%0d want col=%b len=%0d", o.col, o.len, e.col, e.len);
      end
    end
    repeat (GAP + 3) @(negedge clk);
    // Own row left high: the key must not read on any column
    keypadRow = 4'b1000;
    obs_q.delete();
    cmd_key = 4'hF; cmd_hold = 3; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3 + GAP + 5) @(negedge clk);
    total++;
    if (obs_q.size() != 0) begin bad++; $display("FAIL multirow_ownrow_high: got %0d presses want 0", obs_q.size()); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL multirow_idle: got busy=%b want 0", busy); end
    keypadRow = 4'hF;
  endtask

  task automatic test_reset_mid_press();
    int dc0;
    keypadRow = 4'h0;
    cmd_valid = 1'b1;
    cmd_key = 4'h5; cmd_hold = 100;
    @(negedge clk);
    cmd_key = 4'hA; cmd_hold = 2;
    @(negedge clk);
    cmd_key = 4'hC; cmd_hold = 2;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (17) @(negedge clk);
    #1;
    total++;
    if (keypadCol !== col_of(4'h5)) begin bad++; $display("FAIL midpress_pressing: got %b want %b", keypadCol, col_of(4'h5)); end
    rst = 1'b1;
    #1;
    total++;
    if (keypadCol !== 4'hF) begin bad++; $display("FAIL midpress_col: got %b want 1111", keypadCol); end
    total++;
    if ({cmd_ready, busy, done} !== 3'b100) begin bad++; $display("FAIL midpress_flags: got ready/busy/done=%b want 100", {cmd_ready, busy, done}); end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    obs_q.delete();
    dc0 = done_cnt;
    repeat (150) @(negedge clk);
    total++;
    if (obs_q.size() != 0) begin bad++; $display("FAIL midpress_replay: got %0d presses want 0", obs_q.size()); end
    total++;
    if (busy !== 1'b0 || done_cnt != dc0) begin bad++; $display("FAIL midpress_quiet: got busy=%b pulses=%0d want 0 0", busy, done_cnt - dc0); end
    keypadRow = 4'hF;
  endtask

`ifdef KEYPAD_EMU_BOUNCE_EN
  task automatic test_bounce();
    logic [15:0] pat;
    logic [3:0]  want_col;
    exp_t        e;
    // closed cycles after acceptance: bounce 2,4; press 5-7; bounce 9,11
    pat = 16'b0000_1010_1111_0100;
    keypadRow = 4'h0;
    cmd_key = 4'h2; cmd_hold = 3; cmd_valid = 1'b1;
    exp_q.push_back(mk_exp(4'h2, 3));
    @(negedge clk);
    cmd_valid = 1'b0;
    e = exp_q.pop_front();
    for (int k = 0; k <= 15; k++) begin
      #1;
      want_col = pat[k] ? e.col : 4'hF;
      total++;
      if (keypadCol !== want_col) begin bad++; $display("FAIL bounce_col k=%0d: got %b want %b", k, keypadCol, want_col); end
      total++;
      if (done !== (k == 12)) begin bad++; $display("FAIL bounce_done k=%0d: got %b want %b", k, done, (k == 12)); end
      @(negedge clk);
    end
    repeat (GAP + 2) @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL bounce_idle: got busy=%b want 0", busy); end
    keypadRow = 4'hF;
    obs_q.delete();
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
`ifdef KEYPAD_EMU_BOUNCE_EN
    test_bounce();
`else
    test_single_key();
    test_hold_zero();
    test_queue_full();
    test_multi_row();
    test_reset_mid_press();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_emulator.md
# keypad_emulator

Synthesizable 4x4 matrix-keypad emulator that answers the row-scan of the game's keypad scanner exactly as a physical keypad would. It accepts scripted key-press commands through a valid/ready port, queues them, and for each one closes the selected row/column contact for a programmed number of cycles. An inter-key gap follows each press. It sits between the scanner's `keypadRow`/`keypadCol` pins and an autoplay or test source, and stands in for the hardware keypad in regression and demo builds.

## Interface
Parameters:
- `HOLD_W`, 16: width of the per-command hold count.
- `GAP_CYCLES`, 1000: released-contact cycles after every press, at least 1.
- `FIFO_DEPTH`, 4: command queue entries, a power of 2 and at least 2.
- `BOUNCE_CYCLES`, 8: bounce length per edge. Used only when `KEYPAD_EMU_BOUNCE_EN` is defined; at least 1.

Ports:
- `clk`  in  1  single clock; all state is updated on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `keypadRow`  in  4  row drive from the scanner. Active-low; the scanner drives one row low at a time.
- `keypadCol`  out  4  column sense to the scanner. Active-low; idle value is 4'b1111.
- `cmd_valid`  in  1  a command is offered.
- `cmd_ready`  out  1  the queue can accept; equals not-full.
- `cmd_key`  in  4  key code. Row = `cmd_key[3:2]`, column = `cmd_key[1:0]`.
- `cmd_hold`  in  HOLD_W  number of contact-closed cycles; 0 is treated as 1.
- `busy`  out  1  high whenever the FSM is not IDLE or the queue is non-empty.
- `done`  out  1  one-cycle pulse when a press is released.

## Operation
- Command path:
  - A command is accepted on an edge where `cmd_valid && cmd_ready`; `{cmd_key, cmd_hold}` is written to the FIFO.
  - `cmd_ready` is combinational `!full`.
  - `cmd_valid` while full is ignored; nothing is written and nothing is flagged.
  - A simultaneous push and pop when not full is allowed, and occupancy does not change.
- FSM states: IDLE, PRESS, GAP, plus BOUNCE_IN and BOUNCE_OUT when the bounce feature is compiled in.
  - IDLE: the contact is open. If the FIFO is non-empty, pop the head, latch `key_r` and `hold_cnt = max(hold,1)`, and go to PRESS (or BOUNCE_IN).
  - PRESS: the contact is closed. Decrement `hold_cnt`; at 1, go to GAP (or BOUNCE_OUT).
  - GAP: the contact is open. It lasts `GAP_CYCLES` cycles, then returns to IDLE.
  - GAP always returns to IDLE, so consecutive presses are separated by `GAP_CYCLES` + 1 open cycles.
- Column output:
  - `keypadCol[c] = 0` iff the contact is closed, `c == key_r[1:0]`, and `keypadRow[key_r[3:2]] == 0`; otherwise the bit is 1.
  - `keypadCol` is combinational from `keypadRow` and registered state (passive-switch behaviour).
  - If the scanner drives several rows low, the key still reads only on its own column.
- `done` is high during the first GAP cycle only.
- Reset mid-press: the FIFO is flushed, the FSM goes to IDLE, and the contact opens immediately (asynchronously).

## Timing
- Reset values: `keypadCol` = 4'b1111 (for any `keypadRow`), `cmd_ready` = 1, `busy` = 0, `done` = 0; the FSM is in IDLE and the FIFO is empty.
- Latency for a command accepted at edge T with the FSM idle and the FIFO empty:
  - Pop occurs at edge T+1.
  - The contact is closed from T+1 through T+H, which is exactly H cycles.
  - GAP covers T+H+1 to T+H+GAP_CYCLES.
  - IDLE is reached at edge T+H+GAP_CYCLES+1.
- `busy` rises the cycle after acceptance. It falls on the edge entering IDLE with the FIFO empty.
- `hold_cnt` is HOLD_W bits. The maximum hold is 2^HOLD_W − 1 and the counter never wraps.
- The gap counter is sized `$clog2(GAP_CYCLES+1)`.

## Configuration
- `KEYPAD_EMU_BOUNCE_EN` defined:
  - BOUNCE_IN runs for `BOUNCE_CYCLES` cycles before PRESS. BOUNCE_OUT runs for `BOUNCE_CYCLES` cycles before GAP.
  - In both states the contact equals bit 0 of the bounce counter. The counter starts at 0, so the first bounce cycle is open and the contact alternates every cycle.
  - The PRESS duration (H) is unchanged.
  - `done` pulses on the first GAP cycle, after BOUNCE_OUT.
- Undefined: the bounce states, counter and parameter usage are absent, and the contact changes cleanly.

## Test plan
- Single key, no bounce: reset, then `cmd_key`=4'h6, `cmd_hold`=5, `GAP_CYCLES`=3, scanner rotating rows.
  - `keypadCol`=4'b1011 exactly when `keypadRow`=4'b1101, during 5 cycles starting one edge after acceptance; 4'b1111 at all other times.
  - `done` pulses once, 6 cycles after acceptance.
- Hold 0: `cmd_hold`=0 → the contact is closed for exactly 1 cycle.
- Queue full, `FIFO_DEPTH`=4:
  - Push 5 commands back-to-back while the first is pressing: `cmd_ready` falls after the 5th acceptance, and further valid is ignored.
  - Keys are replayed in order, each separated by 4 open cycles.
- Reset mid-press (hold=100, `rst` at cycle 20):
  - `keypadCol`=4'b1111 immediately; `busy`=0; queued commands are not replayed after reset.
- Multi-row drive: `keypadRow`=4'b0000 during a press of key 4'hF → `keypadCol`=4'b0111.
- Bounce, `KEYPAD_EMU_BOUNCE_EN` with `BOUNCE_CYCLES`=4, hold=3:
  - Contact sequence: open, closed, open, closed; then closed ×3; then open, closed, open, closed; then the gap.
  - `done` pulses on the first gap cycle.
